decoder_ctrl_multi: RTL and testbench

- Parametrised, multi-lane successor of the single-lane decode control block.
- Sits between the instruction decoder field extract and the ID/EX pipeline register; decodes LANES instructions per cycle into control bundles and registers them.
- Tracks branch delay slots within a fetch group and across group boundaries, for all branches (not only branch-and-link).
- Honours stall and flush.

---
 rtl/decoder_ctrl_multi_pkg.sv | 149 ++++++++++++++
 rtl/decoder_ctrl_multi_lane.sv | 96 +++++++++
 rtl/decoder_ctrl_multi.sv | 145 ++++++++++++++
 tb/tb_decoder_ctrl_multi.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/decoder_ctrl_multi_pkg.sv
// Shared decode tables for the multi-lane decode control block: opcode and
// funct encodings, ALU operation codes, memory type/size codes and the
// per-lane control bundle.
package decoder_pkg;

  // Primary opcodes
  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_REGIMM  = 6'h01;
  localparam logic [5:0] OP_J       = 6'h02;
  localparam logic [5:0] OP_JAL     = 6'h03;
  localparam logic [5:0] OP_BEQ     = 6'h04;
  localparam logic [5:0] OP_BNE     = 6'h05;
  localparam logic [5:0] OP_BLEZ    = 6'h06;
  localparam logic [5:0] OP_BGTZ    = 6'h07;
  localparam logic [5:0] OP_ADDI    = 6'h08;
  localparam logic [5:0] OP_ADDIU   = 6'h09;
  localparam logic [5:0] OP_SLTI    = 6'h0A;
  localparam logic [5:0] OP_SLTIU   = 6'h0B;
  localparam logic [5:0] OP_ANDI    = 6'h0C;
  localparam logic [5:0] OP_ORI     = 6'h0D;
  localparam logic [5:0] OP_XORI    = 6'h0E;
  localparam logic [5:0] OP_LUI     = 6'h0F;
  localparam logic [5:0] OP_LB      = 6'h20;
  localparam logic [5:0] OP_LH      = 6'h21;
  localparam logic [5:0] OP_LWL     = 6'h22;
  localparam logic [5:0] OP_LW      = 6'h23;
  localparam logic [5:0] OP_LBU     = 6'h24;
  localparam logic [5:0] OP_LHU     = 6'h25;
  localparam logic [5:0] OP_LWR     = 6'h26;
  localparam logic [5:0] OP_SB      = 6'h28;
  localparam logic [5:0] OP_SH      = 6'h29;
  localparam logic [5:0] OP_SWL     = 6'h2A;
  localparam logic [5:0] OP_SW      = 6'h2B;
  localparam logic [5:0] OP_SWR     = 6'h2E;

  // SPECIAL funct codes
  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_JALR = 6'h09;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;
  localparam logic [5:0] FN_SLTU = 6'h2B;

  // REGIMM rt selectors
  localparam logic [4:0] RT_BLTZ   = 5'h00;
  localparam logic [4:0] RT_BGEZ   = 5'h01;
  localparam logic [4:0] RT_BLTZAL = 5'h10;
  localparam logic [4:0] RT_BGEZAL = 5'h11;

  // ALU operation codes
  localparam logic [5:0] ALU_NOP  = 6'd0;
  localparam logic [5:0] ALU_ADD  = 6'd1;
  localparam logic [5:0] ALU_ADDU = 6'd2;
  localparam logic [5:0] ALU_SUB  = 6'd3;
  localparam logic [5:0] ALU_SUBU = 6'd4;
  localparam logic [5:0] ALU_AND  = 6'd5;
  localparam logic [5:0] ALU_OR   = 6'd6;
  localparam logic [5:0] ALU_XOR  = 6'd7;
  localparam logic [5:0] ALU_NOR  = 6'd8;
  localparam logic [5:0] ALU_SLT  = 6'd9;
  localparam logic [5:0] ALU_SLTU = 6'd10;
  localparam logic [5:0] ALU_SLL  = 6'd11;
  localparam logic [5:0] ALU_SRL  = 6'd12;
  localparam logic [5:0] ALU_SRA  = 6'd13;
  localparam logic [5:0] ALU_LUI  = 6'd14;

  // Memory access type and size
  localparam logic [1:0] MEM_NONE  = 2'd0;
  localparam logic [1:0] MEM_LOAD  = 2'd1;
  localparam logic [1:0] MEM_STORE = 2'd2;

  localparam logic [2:0] SIZE_B  = 3'd0;
  localparam logic [2:0] SIZE_H  = 3'd1;
  localparam logic [2:0] SIZE_W  = 3'd2;
  localparam logic [2:0] SIZE_WL = 3'd3;
  localparam logic [2:0] SIZE_WR = 3'd4;

  localparam int REG_RA = 31;

  // One lane's control bundle. The writeback address is carried beside it
  // because its width follows the REG_AW parameter of the instantiating block.
  typedef struct packed {
    logic       undefined_inst;
    logic [5:0] alu_op;
    logic       alu_src;
    logic       alu_imm_src;
    logic [1:0] mem_type;
    logic [2:0] mem_size;
    logic       wb_reg_en;
    logic       unsigned_flag;
  } ctrl_t;

  // R-type ALU functions; ALU_NOP means "not an ALU funct".
  function automatic logic [5:0] funct_alu(input logic [5:0] fn);
    case (fn)
      FN_SLL:  funct_alu = ALU_SLL;
      FN_SRL:  funct_alu = ALU_SRL;
      FN_SRA:  funct_alu = ALU_SRA;
      FN_ADD:  funct_alu = ALU_ADD;
      FN_ADDU: funct_alu = ALU_ADDU;
      FN_SUB:  funct_alu = ALU_SUB;
      FN_SUBU: funct_alu = ALU_SUBU;
      FN_AND:  funct_alu = ALU_AND;
      FN_OR:   funct_alu = ALU_OR;
      FN_XOR:  funct_alu = ALU_XOR;
      FN_NOR:  funct_alu = ALU_NOR;
      FN_SLT:  funct_alu = ALU_SLT;
      FN_SLTU: funct_alu = ALU_SLTU;
      default: funct_alu = ALU_NOP;
    endcase
  endfunction

  // Immediate ALU operations.
  function automatic logic [5:0] imm_alu(input logic [5:0] op);
    case (op)
      OP_ADDI:  imm_alu = ALU_ADD;
      OP_ADDIU: imm_alu = ALU_ADDU;
      OP_SLTI:  imm_alu = ALU_SLT;
      OP_SLTIU: imm_alu = ALU_SLTU;
      OP_ANDI:  imm_alu = ALU_AND;
      OP_ORI:   imm_alu = ALU_OR;
      OP_XORI:  imm_alu = ALU_XOR;
      OP_LUI:   imm_alu = ALU_LUI;
      default:  imm_alu = ALU_NOP;
    endcase
  endfunction

  // Load/store size: the low three opcode bits encode it the same way for
  // both loads and stores.
  function automatic logic [2:0] access_size(input logic [5:0] op);
    case (op[2:0])
      3'd0, 3'd4: access_size = SIZE_B;
      3'd1, 3'd5: access_size = SIZE_H;
      3'd2:       access_size = SIZE_WL;
      3'd3:       access_size = SIZE_W;
      default:    access_size = SIZE_WR;
    endcase
  endfunction

endpackage

// File: rtl/decoder_ctrl_multi_lane.sv
// Single-lane combinational decode: opcode/funct/rt fields to a control
// bundle plus writeback address. Unknown encodings yield a bundle with only
// undefined_inst set.
module decoder_lane
  import decoder_pkg::*;
#(
  parameter int REG_AW = 5
) (
  input  logic [5:0]        opcode,
  input  logic [REG_AW-1:0] rt,
  input  logic [REG_AW-1:0] rd,
  input  logic [5:0]        funct,
  input  logic              is_branch_al,
  output ctrl_t             ctrl,
  output logic [REG_AW-1:0] dest
);

  logic wr;
  logic undef;

  // Table-driven decode; link writeback is qualified by the link flag from field extract
  always_comb begin
    ctrl  = '0;
    dest  = '0;
    wr    = 1'b0;
    undef = 1'b0;
    case (opcode)
      OP_SPECIAL: begin
        if (funct == FN_JR) begin
          ctrl.alu_op = ALU_NOP;
        end else if (funct == FN_JALR) begin
          dest = rd;
          wr   = is_branch_al;
        end else if (funct_alu(funct) != ALU_NOP) begin
          ctrl.alu_op = funct_alu(funct);
          dest        = rd;
          wr          = 1'b1;
        end else begin
          undef = 1'b1;
        end
      end
      OP_REGIMM: begin
        ctrl.alu_op = ALU_SUB;
        if (rt == REG_AW'(RT_BLTZAL) || rt == REG_AW'(RT_BGEZAL)) begin
          dest = REG_AW'(REG_RA);
          wr   = is_branch_al;
        end else if (rt != REG_AW'(RT_BLTZ) && rt != REG_AW'(RT_BGEZ)) begin
          undef = 1'b1;
        end
      end
      OP_J: begin
        ctrl.alu_op = ALU_NOP;
      end
      OP_JAL: begin
        dest = REG_AW'(REG_RA);
        wr   = is_branch_al;
      end
      OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ: begin
        ctrl.alu_op = ALU_SUB;
      end
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI, OP_LUI: begin
        ctrl.alu_op      = imm_alu(opcode);
        ctrl.alu_src     = 1'b1;
        ctrl.alu_imm_src = opcode inside {OP_ANDI, OP_ORI, OP_XORI, OP_LUI};
        dest             = rt;
        wr               = 1'b1;
      end
      OP_LB, OP_LH, OP_LWL, OP_LW, OP_LBU, OP_LHU, OP_LWR: begin
        ctrl.alu_op        = ALU_ADDU;
        ctrl.alu_src       = 1'b1;
        ctrl.mem_type      = MEM_LOAD;
        ctrl.mem_size      = access_size(opcode);
        ctrl.unsigned_flag = opcode inside {OP_LBU, OP_LHU};
        dest               = rt;
        wr                 = 1'b1;
      end
      OP_SB, OP_SH, OP_SWL, OP_SW, OP_SWR: begin
        ctrl.alu_op   = ALU_ADDU;
        ctrl.alu_src  = 1'b1;
        ctrl.mem_type = MEM_STORE;
        ctrl.mem_size = access_size(opcode);
      end
      default: begin
        undef = 1'b1;
      end
    endcase

    if (undef) begin
      ctrl                = '0;
      ctrl.undefined_inst = 1'b1;
      dest                = '0;
    end
    ctrl.wb_reg_en = wr & (|dest) & ~undef;
  end

endmodule

// File: rtl/decoder_ctrl_multi.sv
// Multi-lane decode control: decodes LANES instructions per cycle, chains
// branch delay-slot marking within and across fetch groups, and registers the
// control bundles into the ID/EX boundary with stall/flush handling.
// Optional build macro DECODER_CTRL_DS_BRANCH_TRAP_EN: a valid branch that
// itself sits in a delay slot is flagged undefined and does not arm a slot.
module decoder_ctrl_multi
  import decoder_pkg::*;
#(
  parameter int LANES  = 2,
  parameter int REG_AW = 5
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     stall,
  input  logic                     flush,
  input  logic [LANES-1:0]         valid_in,
  input  logic [6*LANES-1:0]       opcode,
  input  logic [REG_AW*LANES-1:0]  rt,
  input  logic [REG_AW*LANES-1:0]  rd,
  input  logic [6*LANES-1:0]       funct,
  input  logic [LANES-1:0]         is_branch,
  input  logic [LANES-1:0]         is_branch_al,
  output logic [LANES-1:0]         valid_out,
  output logic [LANES-1:0]         in_delay_slot,
  output logic [LANES-1:0]         undefined_inst,
  output logic [6*LANES-1:0]       alu_op,
  output logic [LANES-1:0]         alu_src,
  output logic [LANES-1:0]         alu_imm_src,
  output logic [2*LANES-1:0]       mem_type,
  output logic [3*LANES-1:0]       mem_size,
  output logic [REG_AW*LANES-1:0]  wb_reg_dest,
  output logic [LANES-1:0]         wb_reg_en,
  output logic [LANES-1:0]         unsigned_flag
);

  ctrl_t             lane_ctrl [LANES];
  logic [REG_AW-1:0] lane_dest [LANES];

  ctrl_t             ctrl_p0 [LANES];
  logic [REG_AW-1:0] dest_p0 [LANES];
  logic [LANES-1:0]  ds_p0;
  logic [LANES-1:0]  trap_p0;
  logic              carry;
  logic              last_br;

  ctrl_t             ctrl_p1 [LANES];
  logic [REG_AW-1:0] dest_p1 [LANES];
  logic [LANES-1:0]  vld_p1;
  logic [LANES-1:0]  ds_p1;
  logic              pending_ds;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    decoder_lane #(.REG_AW(REG_AW)) u_lane (
      .opcode       (opcode[6*g +: 6]),
      .rt           (rt[REG_AW*g +: REG_AW]),
      .rd           (rd[REG_AW*g +: REG_AW]),
      .funct        (funct[6*g +: 6]),
      .is_branch_al (is_branch_al[g]),
      .ctrl         (lane_ctrl[g]),
      .dest         (lane_dest[g])
    );
  end

  // Delay-slot chaining from oldest to youngest lane, and the slot state handed to the next group
  always_comb begin
    ds_p0   = '0;
    trap_p0 = '0;
    carry   = pending_ds;
    last_br = pending_ds;
    for (int i = 0; i < LANES; i++) begin
      ds_p0[i] = valid_in[i] & carry;
`ifdef DECODER_CTRL_DS_BRANCH_TRAP_EN
      trap_p0[i] = valid_in[i] & is_branch[i] & carry;
`endif
      carry = valid_in[i] & is_branch[i] & ~trap_p0[i];
      if (valid_in[i]) begin
        last_br = is_branch[i] & ~trap_p0[i];
      end
    end
  end

  // Mask invalid lanes and apply the delay-slot branch trap
  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      ctrl_p0[i] = '0;
      dest_p0[i] = '0;
      if (valid_in[i]) begin
        ctrl_p0[i] = lane_ctrl[i];
        dest_p0[i] = lane_dest[i];
        if (trap_p0[i]) begin
          ctrl_p0[i].undefined_inst = 1'b1;
          ctrl_p0[i].wb_reg_en      = 1'b0;
        end
      end
    end
  end

  // ---- stage boundary p0 -> p1: ID/EX register with flush over stall ----
  always_ff @(posedge clk) begin
    if (!rst || flush) begin
      vld_p1     <= '0;
      ds_p1      <= '0;
      pending_ds <= 1'b0;
      for (int i = 0; i < LANES; i++) begin
        ctrl_p1[i] <= '0;
        dest_p1[i] <= '0;
      end
    end else if (!stall) begin
      vld_p1     <= valid_in;
      ds_p1      <= ds_p0;
      pending_ds <= last_br;
      for (int i = 0; i < LANES; i++) begin
        ctrl_p1[i] <= ctrl_p0[i];
        dest_p1[i] <= dest_p0[i];
      end
    end
  end

  // Flatten the registered per-lane bundles onto the output buses
  always_comb begin
    valid_out      = vld_p1;
    in_delay_slot  = ds_p1;
    undefined_inst = '0;
    alu_op         = '0;
    alu_src        = '0;
    alu_imm_src    = '0;
    mem_type       = '0;
    mem_size       = '0;
    wb_reg_dest    = '0;
    wb_reg_en      = '0;
    unsigned_flag  = '0;
    for (int i = 0; i < LANES; i++) begin
      undefined_inst[i]               = ctrl_p1[i].undefined_inst;
      alu_op[6*i +: 6]                = ctrl_p1[i].alu_op;
      alu_src[i]                      = ctrl_p1[i].alu_src;
      alu_imm_src[i]                  = ctrl_p1[i].alu_imm_src;
      mem_type[2*i +: 2]              = ctrl_p1[i].mem_type;
      mem_size[3*i +: 3]              = ctrl_p1[i].mem_size;
      wb_reg_dest[REG_AW*i +: REG_AW] = dest_p1[i];
      wb_reg_en[i]                    = ctrl_p1[i].wb_reg_en;
      unsigned_flag[i]                = ctrl_p1[i].unsigned_flag;
    end
  end

endmodule

// File: tb/tb_decoder_ctrl_multi.sv
// Directed bench for decoder_ctrl_multi with LANES=2, REG_AW=5. Expected
// values are hand-derived from the instruction encodings. Builds with or
// without DECODER_CTRL_DS_BRANCH_TRAP_EN.
module tb_decoder_ctrl_multi;

  localparam int LANES  = 2;
  localparam int REG_AW = 5;

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    stall;
  logic                    flush;
  logic [LANES-1:0]        valid_in;
  logic [6*LANES-1:0]      opcode;
  logic [REG_AW*LANES-1:0] rt;
  logic [REG_AW*LANES-1:0] rd;
  logic [6*LANES-1:0]      funct;
  logic [LANES-1:0]        is_branch;
  logic [LANES-1:0]        is_branch_al;
  logic [LANES-1:0]        valid_out;
  logic [LANES-1:0]        in_delay_slot;
  logic [LANES-1:0]        undefined_inst;
  logic [6*LANES-1:0]      alu_op;
  logic [LANES-1:0]        alu_src;
  logic [LANES-1:0]        alu_imm_src;
  logic [2*LANES-1:0]      mem_type;
  logic [3*LANES-1:0]      mem_size;
  logic [REG_AW*LANES-1:0] wb_reg_dest;
  logic [LANES-1:0]        wb_reg_en;
  logic [LANES-1:0]        unsigned_flag;

  int n_checks = 0;
  int n_errors = 0;

  decoder_ctrl_multi #(.LANES(LANES), .REG_AW(REG_AW)) dut (
    .clk            (clk),
    .rst            (rst),
    .stall          (stall),
    .flush          (flush),
    .valid_in       (valid_in),
    .opcode         (opcode),
    .rt             (rt),
    .rd             (rd),
    .funct          (funct),
    .is_branch      (is_branch),
    .is_branch_al   (is_branch_al),
    .valid_out      (valid_out),
    .in_delay_slot  (in_delay_slot),
    .undefined_inst (undefined_inst),
    .alu_op         (alu_op),
    .alu_src        (alu_src),
    .alu_imm_src    (alu_imm_src),
    .mem_type       (mem_type),
    .mem_size       (mem_size),
    .wb_reg_dest    (wb_reg_dest),
    .wb_reg_en      (wb_reg_en),
    .unsigned_flag  (unsigned_flag)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_lane(input int l, input logic v, input logic [5:0] op,
                          input logic [4:0] t, input logic [4:0] d,
                          input logic [5:0] fn, input logic br, input logic al);
    valid_in[l]          = v;
    opcode[6*l +: 6]     = op;
    rt[5*l +: 5]         = t;
    rd[5*l +: 5]         = d;
    funct[6*l +: 6]      = fn;
    is_branch[l]         = br;
    is_branch_al[l]      = al;
  endtask

  task automatic rand_in();
    valid_in     = 2'($urandom);
    opcode       = 12'($urandom);
    rt           = 10'($urandom);
    rd           = 10'($urandom);
    funct        = 12'($urandom);
    is_branch    = 2'($urandom);
    is_branch_al = 2'($urandom);
  endtask

  initial begin
    rst   = 1'b0;
    stall = 1'b0;
    flush = 1'b0;
    rand_in();
    step();
    rand_in();
    step();
    check("rst_valid",   32'(valid_out), 32'd0);
    check("rst_ds",      32'(in_delay_slot), 32'd0);
    check("rst_undef",   32'(undefined_inst), 32'd0);
    check("rst_aluop",   32'(alu_op), 32'd0);
    check("rst_memtype", 32'(mem_type), 32'd0);
    check("rst_wbdest",  32'(wb_reg_dest), 32'd0);
    check("rst_wben",    32'(wb_reg_en), 32'd0);

    // lane0 BEQ, lane1 ADDU rd=5
    rst = 1'b1;
    set_lane(0, 1, 6'h04, 5'd1, 5'd0, 6'h00, 1, 0);
    set_lane(1, 1, 6'h00, 5'd2, 5'd5, 6'h21, 0, 0);
    step();
    check("a_valid",  32'(valid_out), 32'b11);
    check("a_ds",     32'(in_delay_slot), 32'b10);
    check("a_aluop",  32'(alu_op), 32'({6'd2, 6'd3}));
    check("a_wbdest", 32'(wb_reg_dest), 32'({5'd5, 5'd0}));
    check("a_wben",   32'(wb_reg_en), 32'b10);

    // ADDU rd=3, JAL
    set_lane(0, 1, 6'h00, 5'd1, 5'd3, 6'h21, 0, 0);
    set_lane(1, 1, 6'h03, 5'd0, 5'd0, 6'h00, 1, 1);
    step();
    check("b_ds",     32'(in_delay_slot), 32'b00);
    check("b_wbdest", 32'(wb_reg_dest), 32'({5'd31, 5'd3}));
    check("b_wben",   32'(wb_reg_en), 32'b11);

    // bubble group
    set_lane(0, 0, 6'h23, 5'd7, 5'd0, 6'h00, 1, 0);
    set_lane(1, 0, 6'h04, 5'd7, 5'd0, 6'h00, 1, 0);
    step();
    check("bub_valid", 32'(valid_out), 32'b00);
    check("bub_aluop", 32'(alu_op), 32'd0);
    check("bub_ds",    32'(in_delay_slot), 32'b00);

    // LW rt=8, SW rt=9: lane0 is the JAL slot
    set_lane(0, 1, 6'h23, 5'd8, 5'd0, 6'h00, 0, 0);
    set_lane(1, 1, 6'h2B, 5'd9, 5'd0, 6'h00, 0, 0);
    step();
    check("d_ds",      32'(in_delay_slot), 32'b01);
    check("d_memtype", 32'(mem_type), 32'b10_01);
    check("d_memsize", 32'(mem_size), 32'({3'd2, 3'd2}));
    check("d_wbdest",  32'(wb_reg_dest), 32'({5'd0, 5'd8}));
    check("d_wben",    32'(wb_reg_en), 32'b01);
    check("d_alusrc",  32'(alu_src), 32'b11);

    // ORI rt=4, BNE (arms pending slot)
    set_lane(0, 1, 6'h0D, 5'd4, 5'd0, 6'h00, 0, 0);
    set_lane(1, 1, 6'h05, 5'd2, 5'd0, 6'h00, 1, 0);
    step();
    check("e_aluop",  32'(alu_op), 32'({6'd3, 6'd6}));
    check("e_immsrc", 32'(alu_imm_src), 32'b01);
    check("e_wbdest", 32'(wb_reg_dest), 32'({5'd0, 5'd4}));

    // stall for 3 cycles with changing inputs
    stall = 1'b1;
    for (int c = 0; c < 3; c++) begin
      rand_in();
      step();
      check("stall_valid",  32'(valid_out), 32'b11);
      check("stall_aluop",  32'(alu_op), 32'({6'd3, 6'd6}));
      check("stall_wbdest", 32'(wb_reg_dest), 32'({5'd0, 5'd4}));
      check("stall_immsrc", 32'(alu_imm_src), 32'b01);
    end

    // flush together with stall
    flush = 1'b1;
    rand_in();
    step();
    check("flush_valid", 32'(valid_out), 32'b00);
    stall = 1'b0;
    flush = 1'b0;
    set_lane(0, 1, 6'h00, 5'd1, 5'd7, 6'h21, 0, 0);
    set_lane(1, 1, 6'h00, 5'd1, 5'd0, 6'h21, 0, 0);
    step();
    check("pf_ds",     32'(in_delay_slot), 32'b00);
    check("pf_wben",   32'(wb_reg_en), 32'b01);
    check("pf_wbdest", 32'(wb_reg_dest), 32'({5'd0, 5'd7}));

    // undefined opcode in lane0
    set_lane(0, 1, 6'h3F, 5'd3, 5'd3, 6'h21, 0, 0);
    set_lane(1, 1, 6'h00, 5'd1, 5'd2, 6'h21, 0, 0);
    step();
    check("u_undef", 32'(undefined_inst), 32'b01);
    check("u_valid", 32'(valid_out), 32'b11);
    check("u_wben",  32'(wb_reg_en), 32'b10);
    check("u_aluop", 32'(alu_op), 32'({6'd2, 6'd0}));

    // BEQ, BNE: branch in a delay slot
    set_lane(0, 1, 6'h04, 5'd1, 5'd0, 6'h00, 1, 0);
    set_lane(1, 1, 6'h05, 5'd1, 5'd0, 6'h00, 1, 0);
    step();
    check("g_ds", 32'(in_delay_slot), 32'b10);
`ifdef DECODER_CTRL_DS_BRANCH_TRAP_EN
    check("g_undef", 32'(undefined_inst), 32'b10);
`else
    check("g_undef", 32'(undefined_inst), 32'b00);
`endif
    set_lane(0, 1, 6'h00, 5'd1, 5'd1, 6'h21, 0, 0);
    set_lane(1, 1, 6'h00, 5'd1, 5'd2, 6'h21, 0, 0);
    step();
`ifdef DECODER_CTRL_DS_BRANCH_TRAP_EN
    check("g2_ds", 32'(in_delay_slot), 32'b00);
`else
    check("g2_ds", 32'(in_delay_slot), 32'b01);
`endif

    // BEQ with lane1 invalid, then cross-group slot into lane0
    set_lane(0, 1, 6'h04, 5'd1, 5'd0, 6'h00, 1, 0);
    set_lane(1, 0, 6'h23, 5'd6, 5'd0, 6'h00, 0, 0);
    step();
    check("h_valid",   32'(valid_out), 32'b01);
    check("h_ds",      32'(in_delay_slot), 32'b00);
    check("h_memtype", 32'(mem_type), 32'd0);
    check("h_aluop",   32'(alu_op), 32'({6'd0, 6'd3}));
    set_lane(0, 1, 6'h00, 5'd1, 5'd1, 6'h21, 0, 0);
    set_lane(1, 0, 6'h00, 5'd1, 5'd2, 6'h21, 0, 0);
    step();
    check("i_ds",   32'(in_delay_slot), 32'b01);
    check("i_wben", 32'(wb_reg_en), 32'b01);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
